wash_sequencer: RTL and testbench
=================================

// Module: wash_sequencer
// PURPOSE
//  Washer master controller: drives the state/msg bus that the display path (ViewController)
//  decodes into 7-seg and LED outputs.
//  - Program select, run/pause, per-stage countdown: wash -> rinse xN -> spin -> done.
//  - Button inputs are single-cycle pulses from the debouncer. Outputs are fully registered.
// PARAMETERS
//  TICK_DIV    50_000_000  cp cycles per time unit (benches use 4); prescaler width $clog2(TICK_DIV)
//  BEEP_UNITS  3           time units buzzer stays high after entering DONE
// PORTS
//  cp      in   1   clock; all logic on posedge cp
//  rst     in   1   synchronous reset, active-high
//  power   in   1   power toggle pulse
//  start   in   1   start/pause/resume pulse
//  mode    in   1   next-program pulse (honoured in SETUP only)
//  state   out  3   0 OFF, 1 SETUP, 2 WASH, 3 RINSE, 4 SPIN, 5 PAUSE, 6 DONE
//  msg     out  26  {stage_left[25:23], total_left[22:19], wash_t[18:16], rinse_t[15:13],
//                    spin_t[12:10], water[9:6], rinse_cnt[5:3], prog[2:0]}
//  buzzer  out  1   high during first BEEP_UNITS units of DONE
// BEHAVIOUR
//  Reset: state=0, msg=0, buzzer=0, prescaler=0. Every output updates 1 cycle after its cause.
//  Program ROM (wash,rinse,rinse_cnt,spin,water; total=wash+rinse*cnt+spin):
//    0:3,2,2,3,8(10)  1:2,1,1,2,6(5)  2:4,3,2,4,12(14)  3:2,2,2,1,10(7)
//    4:0,2,1,2,8(4)   5:0,0,0,3,0(3)
//  Load(p): prog=p, ROM fields into msg, total_left=total, stage_left=0.
//  Priority when pulses coincide: power > start > mode.
//  OFF:   power -> SETUP, Load(0). start/mode ignored. msg held at 0.
//  Any non-OFF state: power -> OFF, msg=0, buzzer=0, prescaler=0.
//  SETUP: mode -> Load((prog==5)?0:prog+1).
//         start -> first stage with non-zero time:
//           WASH if wash_t>0; else RINSE if rinse_cnt>0 && rinse_t>0; else SPIN.
//         On entry: stage_left = that stage's time; prescaler cleared.
//  WASH/RINSE/SPIN:
//    - Prescaler counts 0..TICK_DIV-1. Wrap = tick: stage_left-1, total_left-1.
//    - Tick with stage_left==1 completes the stage:
//        WASH  -> RINSE, or SPIN if the rinse phase is empty.
//        RINSE -> rinse_cnt-1. If it is still >0, reload rinse_t and stay in RINSE.
//                 Otherwise go to SPIN, with rinse_cnt=0.
//        SPIN  -> DONE.
//    - start -> PAUSE. Paused stage is remembered; prescaler frozen.
//      If start and a wrap fall in the same cycle, the tick is dropped.
//      Prescaler holds TICK_DIV-1, so the tick fires on the first cycle after resume.
//  PAUSE: start -> the remembered stage; prescaler resumes from its held value. mode ignored.
//  DONE:  msg = {23'b0, prog}; buzzer=1 on entry.
//         Buzzer drops after BEEP_UNITS ticks; prescaler keeps running for this count.
//         start -> SETUP, Load(prog).
//  Invariant while running: total_left == stage_left + remaining unstarted stage time.
//  total_left never wraps below 0.
// TESTING (TICK_DIV=4, BEEP_UNITS=3)
//  1. rst 2 cycles -> state=0, msg=0, buzzer=0. Then power pulse
//     -> state=1, msg=26'b000_1010_011_010_011_1000_010_000.
//  2. mode x6 in SETUP -> prog 1,2,3,4,5,0. Pulse mode in OFF -> no change.
//  3. prog 1, start -> state=2, stage_left=2, total=5.
//     4 cycles later -> stage_left=1, total=4. Then RINSE, SPIN, DONE after 20 cycles.
//     DONE msg=26'd1, buzzer high for 12 cycles.
//  4. Pause mid-WASH on a wrap cycle -> state=5, counts frozen 10 cycles.
//     start -> state=2, tick lands the first cycle after resume.
//  5. prog 5, start -> state=4 (SPIN) directly. prog 4 -> state=3 (RINSE).
//  6. power during SPIN -> state=0, msg=0 next cycle.
//     rst asserted mid-RINSE -> reset values, even with start asserted the same cycle.

Source files
------------

// File: rtl/wash_sequencer.sv
// wash_sequencer: washer master controller.
// Sequences wash -> rinse xN -> spin -> done for one of six programs and
// publishes state plus a packed message bus for the display path.
module wash_sequencer #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int BEEP_UNITS = 3
) (
    input  logic        cp,
    input  logic        rst,
    input  logic        power,
    input  logic        start,
    input  logic        mode,
    output logic [2:0]  state,
    output logic [25:0] msg,
    output logic        buzzer
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRE_MAX   = PW'(TICK_DIV - 1);
    localparam int             BW        = (BEEP_UNITS > 0) ? $clog2(BEEP_UNITS + 1) : 1;
    localparam logic [BW-1:0]  BEEP_INIT = BW'(BEEP_UNITS);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_SETUP = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_PAUSE = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef struct packed {
        logic [2:0] wash;
        logic [2:0] rinse;
        logic [2:0] cnt;
        logic [2:0] spin;
        logic [3:0] water;
    } prog_t;

    // Program table; unused codes fall back to program 0.
    function automatic prog_t romLookup(input logic [2:0] p);
        case (p)
            3'd1:    romLookup = '{3'd2, 3'd1, 3'd1, 3'd2, 4'd6};
            3'd2:    romLookup = '{3'd4, 3'd3, 3'd2, 3'd4, 4'd12};
            3'd3:    romLookup = '{3'd2, 3'd2, 3'd2, 3'd1, 4'd10};
            3'd4:    romLookup = '{3'd0, 3'd2, 3'd1, 3'd2, 4'd8};
            3'd5:    romLookup = '{3'd0, 3'd0, 3'd0, 3'd3, 4'd0};
            default: romLookup = '{3'd3, 3'd2, 3'd2, 3'd3, 4'd8};
        endcase
    endfunction

    state_t        r_state, r_resume, w_state, w_resume;
    logic [PW-1:0] r_pre, w_pre;
    logic [2:0]    r_stage, r_wash, r_rinse, r_spin, r_cnt, r_prog;
    logic [2:0]    w_stage, w_wash, w_rinse, w_spin, w_cnt, w_prog;
    logic [3:0]    r_total, r_water, w_total, w_water;
    logic          r_buzzer, w_buzzer;
    logic [BW-1:0] r_beep, w_beep;
    logic          w_tick, w_doLoad, w_doClear;
    logic [2:0]    w_loadProg;
    prog_t         w_rom;

    // Next-state and next-message computation for the whole controller.
    always_comb begin
        w_state    = r_state;
        w_resume   = r_resume;
        w_pre      = r_pre;
        w_stage    = r_stage;
        w_total    = r_total;
        w_wash     = r_wash;
        w_rinse    = r_rinse;
        w_spin     = r_spin;
        w_water    = r_water;
        w_cnt      = r_cnt;
        w_prog     = r_prog;
        w_buzzer   = r_buzzer;
        w_beep     = r_beep;
        w_doLoad   = 1'b0;
        w_doClear  = 1'b0;
        w_loadProg = r_prog;
        w_tick     = (r_pre == PRE_MAX);

        if (r_state == S_OFF) begin
            if (power) begin
                w_state    = S_SETUP;
                w_doLoad   = 1'b1;
                w_loadProg = 3'd0;
            end
        end else if (power) begin
            w_state   = S_OFF;
            w_doClear = 1'b1;
        end else begin
            case (r_state)
                S_SETUP: begin
                    if (start) begin
                        w_pre = '0;
                        if (r_wash != 3'd0) begin
                            w_state = S_WASH;
                            w_stage = r_wash;
                        end else if (r_cnt != 3'd0 && r_rinse != 3'd0) begin
                            w_state = S_RINSE;
                            w_stage = r_rinse;
                        end else begin
                            w_state = S_SPIN;
                            w_stage = r_spin;
                        end
                    end else if (mode) begin
                        w_doLoad   = 1'b1;
                        w_loadProg = (r_prog == 3'd5) ? 3'd0 : r_prog + 3'd1;
                    end
                end
                S_WASH, S_RINSE, S_SPIN: begin
                    if (start) begin
                        w_state  = S_PAUSE;
                        w_resume = r_state;
                    end else begin
                        w_pre = w_tick ? '0 : r_pre + PW'(1);
                        if (w_tick) begin
                            if (r_total != 4'd0) begin
                                w_total = r_total - 4'd1;
                            end
                            if (r_stage > 3'd1) begin
                                w_stage = r_stage - 3'd1;
                            end else if (r_state == S_WASH) begin
                                if (r_cnt != 3'd0 && r_rinse != 3'd0) begin
                                    w_state = S_RINSE;
                                    w_stage = r_rinse;
                                end else begin
                                    w_state = S_SPIN;
                                    w_stage = r_spin;
                                end
                            end else if (r_state == S_RINSE) begin
                                if (r_cnt > 3'd1) begin
                                    w_cnt   = r_cnt - 3'd1;
                                    w_stage = r_rinse;
                                end else begin
                                    w_cnt   = 3'd0;
                                    w_state = S_SPIN;
                                    w_stage = r_spin;
                                end
                            end else begin
                                w_state  = S_DONE;
                                w_stage  = 3'd0;
                                w_total  = 4'd0;
                                w_wash   = 3'd0;
                                w_rinse  = 3'd0;
                                w_spin   = 3'd0;
                                w_water  = 4'd0;
                                w_cnt    = 3'd0;
                                w_buzzer = (BEEP_UNITS > 0);
                                w_beep   = BEEP_INIT;
                            end
                        end
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        w_state = r_resume;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        w_state  = S_SETUP;
                        w_doLoad = 1'b1;
                        w_buzzer = 1'b0;
                        w_beep   = '0;
                    end else if (r_beep != '0) begin
                        w_pre = w_tick ? '0 : r_pre + PW'(1);
                        if (w_tick) begin
                            w_beep = r_beep - BW'(1);
                            if (r_beep == BW'(1)) begin
                                w_buzzer = 1'b0;
                            end
                        end
                    end
                end
                default: w_state = S_OFF;
            endcase
        end

        w_rom = romLookup(w_loadProg);
        if (w_doClear) begin
            w_pre    = '0;
            w_stage  = 3'd0;
            w_total  = 4'd0;
            w_wash   = 3'd0;
            w_rinse  = 3'd0;
            w_spin   = 3'd0;
            w_water  = 4'd0;
            w_cnt    = 3'd0;
            w_prog   = 3'd0;
            w_buzzer = 1'b0;
            w_beep   = '0;
        end
        if (w_doLoad) begin
            w_pre   = '0;
            w_prog  = w_loadProg;
            w_stage = 3'd0;
            w_wash  = w_rom.wash;
            w_rinse = w_rom.rinse;
            w_cnt   = w_rom.cnt;
            w_spin  = w_rom.spin;
            w_water = w_rom.water;
            w_total = 4'(w_rom.wash) + 4'(w_rom.rinse) * 4'(w_rom.cnt) + 4'(w_rom.spin);
        end
    end

    // State and message registers, cleared by synchronous reset.
    always_ff @(posedge cp) begin
        if (rst) begin
            r_state  <= S_OFF;
            r_resume <= S_OFF;
            r_pre    <= '0;
            r_stage  <= 3'd0;
            r_total  <= 4'd0;
            r_wash   <= 3'd0;
            r_rinse  <= 3'd0;
            r_spin   <= 3'd0;
            r_water  <= 4'd0;
            r_cnt    <= 3'd0;
            r_prog   <= 3'd0;
            r_buzzer <= 1'b0;
            r_beep   <= '0;
        end else begin
            r_state  <= w_state;
            r_resume <= w_resume;
            r_pre    <= w_pre;
            r_stage  <= w_stage;
            r_total  <= w_total;
            r_wash   <= w_wash;
            r_rinse  <= w_rinse;
            r_spin   <= w_spin;
            r_water  <= w_water;
            r_cnt    <= w_cnt;
            r_prog   <= w_prog;
            r_buzzer <= w_buzzer;
            r_beep   <= w_beep;
        end
    end

    assign state  = r_state;
    assign msg    = {r_stage, r_total, r_wash, r_rinse, r_spin, r_water, r_cnt, r_prog};
    assign buzzer = r_buzzer;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed plus randomized bench for wash_sequencer,
// compared cycle by cycle against a unit-queue model of the wash program.
module tb_wash_sequencer;

    localparam int TD = 4;
    localparam int BU = 3;

    logic        cp = 1'b0;
    logic        rst = 1'b1;
    logic        power = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  state;
    logic [25:0] msg;
    logic        buzzer;

    int errors = 0;
    int checks = 0;

    always #5 cp = ~cp;

    wash_sequencer #(.TICK_DIV(TD), .BEEP_UNITS(BU)) dut (
        .cp    (cp),
        .rst   (rst),
        .power (power),
        .start (start),
        .mode  (mode),
        .state (state),
        .msg   (msg),
        .buzzer(buzzer)
    );

    // Program table as plain numbers: wash, rinse, rinse count, spin, water.
    int romWash[6]  = '{3, 2, 4, 2, 0, 0};
    int romRinse[6] = '{2, 1, 3, 2, 2, 0};
    int romCnt[6]   = '{2, 1, 2, 2, 1, 0};
    int romSpin[6]  = '{3, 2, 4, 1, 2, 3};
    int romWater[6] = '{8, 6, 12, 10, 8, 0};

    // The model views a run as a queue of time units, each tagged with its
    // stage and rinse repetition; a tick simply pops the head unit.
    typedef struct packed {
        logic [2:0] stg;
        logic [2:0] rep;
    } unit_t;

    localparam int M_OFF = 0, M_SETUP = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;

    unit_t mQueue[$];
    int    mMode  = M_OFF;
    int    mProg  = 0;
    int    mPhase = 0;
    int    mBeep  = 0;

    logic [2:0]  eState;
    logic [25:0] eMsg;
    logic        eBuz;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int runLength();
        int n = 0;
        for (int i = 0; i < mQueue.size(); i++) begin
            if (mQueue[i].stg != mQueue[0].stg || mQueue[i].rep != mQueue[0].rep) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [25:0] setupMsg(input int p);
        int total = romWash[p] + romRinse[p] * romCnt[p] + romSpin[p];
        return {3'd0, 4'(total), 3'(romWash[p]), 3'(romRinse[p]), 3'(romSpin[p]),
                4'(romWater[p]), 3'(romCnt[p]), 3'(p)};
    endfunction

    // Lay out every time unit of the selected program in execution order.
    task automatic buildQueue(input int p);
        unit_t u;
        mQueue.delete();
        for (int i = 0; i < romWash[p]; i++) begin
            u = '{3'd2, 3'd0};
            mQueue.push_back(u);
        end
        for (int r = 0; r < romCnt[p]; r++) begin
            for (int i = 0; i < romRinse[p]; i++) begin
                u = '{3'd3, 3'(r)};
                mQueue.push_back(u);
            end
        end
        for (int i = 0; i < romSpin[p]; i++) begin
            u = '{3'd4, 3'd0};
            mQueue.push_back(u);
        end
    endtask

    // Advance the model by one clock given the inputs sampled at that edge.
    task automatic modelStep(input logic r, input logic p, input logic s, input logic m);
        if (r) begin
            mMode = M_OFF; mProg = 0; mPhase = 0; mBeep = 0; mQueue.delete();
        end else if (mMode == M_OFF) begin
            if (p) begin mMode = M_SETUP; mProg = 0; end
        end else if (p) begin
            mMode = M_OFF; mProg = 0; mPhase = 0; mBeep = 0; mQueue.delete();
        end else begin
            case (mMode)
                M_SETUP: begin
                    if (s) begin
                        buildQueue(mProg);
                        mPhase = 0;
                        mMode  = M_RUN;
                    end else if (m) begin
                        mProg = (mProg + 1) % 6;
                    end
                end
                M_RUN: begin
                    if (s) begin
                        mMode = M_PAUSE;
                    end else if (mPhase == TD - 1) begin
                        mPhase = 0;
                        void'(mQueue.pop_front());
                        if (mQueue.size() == 0) begin
                            mMode = M_DONE;
                            mBeep = BU;
                        end
                    end else begin
                        mPhase++;
                    end
                end
                M_PAUSE: if (s) mMode = M_RUN;
                M_DONE: begin
                    if (s) begin
                        mMode = M_SETUP;
                        mBeep = 0;
                    end else if (mBeep > 0) begin
                        if (mPhase == TD - 1) begin
                            mPhase = 0;
                            mBeep--;
                        end else begin
                            mPhase++;
                        end
                    end
                end
                default: mMode = M_OFF;
            endcase
        end
    endtask

    task automatic computeExpected();
        int cntShown;
        eState = 3'd0; eMsg = '0; eBuz = 1'b0;
        case (mMode)
            M_SETUP: begin
                eState = 3'd1;
                eMsg   = setupMsg(mProg);
            end
            M_RUN, M_PAUSE: begin
                if (mQueue[0].stg == 3'd2)      cntShown = romCnt[mProg];
                else if (mQueue[0].stg == 3'd3) cntShown = romCnt[mProg] - int'(mQueue[0].rep);
                else                            cntShown = 0;
                eState = (mMode == M_RUN) ? mQueue[0].stg : 3'd5;
                eMsg   = {3'(runLength()), 4'(mQueue.size()), 3'(romWash[mProg]),
                          3'(romRinse[mProg]), 3'(romSpin[mProg]), 4'(romWater[mProg]),
                          3'(cntShown), 3'(mProg)};
            end
            M_DONE: begin
                eState = 3'd6;
                eMsg   = 26'(mProg);
                eBuz   = (mBeep > 0);
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, step the model at the edge, compare 1 time unit later.
    task automatic applyStimulus(input logic r, input logic p, input logic s, input logic m, input string tag);
        rst = r; power = p; start = s; mode = m;
        @(posedge cp);
        modelStep(r, p, s, m);
        #1;
        rst = 1'b0; power = 1'b0; start = 1'b0; mode = 1'b0;
        computeExpected();
        checkOutput({tag, ":state"}, 32'(state), 32'(eState));
        checkOutput({tag, ":msg"}, 32'(msg), 32'(eMsg));
        checkOutput({tag, ":buzzer"}, 32'(buzzer), 32'(eBuz));
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic pressMode(input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    // Directed scenarios first, then a long randomized pulse stream.
    initial begin
        int highCount;
        logic r, p, s, m;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "reset");
        checkOutput("reset_msg", 32'(msg), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "power_on");
        checkOutput("power_on_msg", 32'(msg), 32'(26'b000_1010_011_010_011_1000_010_000));

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "mode_cycle");
            checkOutput("mode_prog", 32'(msg[2:0]), 32'((i + 1) % 6));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "power_off");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "mode_in_off");
        checkOutput("mode_in_off_state", 32'(state), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "power_on2");

        pressMode(1, "sel_prog1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "prog1_start");
        checkOutput("prog1_stage", 32'(msg[25:23]), 32'd2);
        checkOutput("prog1_total", 32'(msg[22:19]), 32'd5);
        idle(4, "prog1_wash");
        checkOutput("prog1_tick_stage", 32'(msg[25:23]), 32'd1);
        checkOutput("prog1_tick_total", 32'(msg[22:19]), 32'd4);
        idle(16, "prog1_run");
        checkOutput("prog1_done_state", 32'(state), 32'd6);
        checkOutput("prog1_done_msg", 32'(msg), 32'd1);
        highCount = buzzer ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "beep");
            if (buzzer) highCount++;
        end
        checkOutput("beep_cycles", 32'(highCount), 32'd12);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "done_to_setup");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "pause_start");
        idle(3, "pause_pre");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "pause_on_wrap");
        checkOutput("pause_state", 32'(state), 32'd5);
        checkOutput("pause_stage", 32'(msg[25:23]), 32'd2);
        idle(10, "paused");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "resume");
        checkOutput("resume_state", 32'(state), 32'd2);
        idle(1, "resume_tick");
        checkOutput("resume_tick_stage", 32'(msg[25:23]), 32'd1);
        checkOutput("resume_tick_total", 32'(msg[22:19]), 32'd4);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "off3");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "on3");
        pressMode(5, "sel_prog5");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "prog5_start");
        checkOutput("prog5_spin", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "off4");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "on4");
        pressMode(4, "sel_prog4");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "prog4_start");
        checkOutput("prog4_rinse", 32'(state), 32'd3);
        idle(8, "prog4_rinse_run");
        checkOutput("prog4_spin", 32'(state), 32'd4);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "power_in_spin");
        checkOutput("power_spin_state", 32'(state), 32'd0);
        checkOutput("power_spin_msg", 32'(msg), 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "on5");
        pressMode(4, "sel_prog4b");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "prog4b_start");
        idle(2, "prog4b_rinse");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "reset_with_start");
        checkOutput("rst_start_state", 32'(state), 32'd0);
        checkOutput("rst_start_msg", 32'(msg), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 400) == 0;
            p = ($urandom % 70) == 0;
            s = ($urandom % 12) == 0;
            m = ($urandom % 6) == 0;
            applyStimulus(r, p, s, m, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
